// File: rtl/vector_addr_sequencer.sv
// vector_addr_sequencer
//   Element/address sequencer for the vector memory stage. A start command
//   walks operand memory from a base address and issues one element address
//   per unstalled cycle: VLEN elements for a vector op, 1 for a scalar op.
//   counter_o and op_type_o feed the downstream completion-flag compare.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   start                 start request, sampled only in IDLE
//   op_type               1 = vector (VLEN elements), 0 = scalar (1 element)
//   base_addr [N-1:0]     first element address
//   stride    [N-1:0]     address step (honoured only with ADDR_SEQ_STRIDE_EN)
//   stall                 hold issue this cycle
//   addr_o    [N-1:0]     current element address
//   valid_o               addr_o is a live element
//   counter_o [N-1:0]     elements issued in current/last op
//   op_type_o             latched op_type of current/last op
//   busy_o                state is RUN or DONE
//   done_o                one-cycle pulse after the last element issues
//
// Build option
//   ADDR_SEQ_STRIDE_EN    defined: addr_o advances by the stride latched at
//                         start. Undefined: stride is ignored, step is 1.
module vector_addr_sequencer #(
  parameter int N    = 6,
  parameter int VLEN = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_type,
  input  logic [N-1:0] base_addr,
  input  logic [N-1:0] stride,
  input  logic         stall,
  output logic [N-1:0] addr_o,
  output logic         valid_o,
  output logic [N-1:0] counter_o,
  output logic         op_type_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] last_idx;
  logic [N-1:0] step;
  logic         issue;

  // Index of the final element for the latched op.
  assign last_idx = op_type_o ? N'(VLEN - 1) : '0;
  assign issue    = (state == RUN) && !stall;

`ifdef ADDR_SEQ_STRIDE_EN
  logic [N-1:0] stride_q;
  assign step = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign step = N'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && counter_o == last_idx) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered copies of the next state so every output
  // lines up with the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_o    <= '0;
      valid_o   <= 1'b0;
      counter_o <= '0;
      op_type_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
`ifdef ADDR_SEQ_STRIDE_EN
      stride_q  <= '0;
`endif
    end else begin
      valid_o <= (state_nxt == RUN);
      busy_o  <= (state_nxt != IDLE);
      done_o  <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        op_type_o <= op_type;
        addr_o    <= base_addr;
        counter_o <= '0;
`ifdef ADDR_SEQ_STRIDE_EN
        stride_q  <= stride;
`endif
      end else if (issue) begin
        counter_o <= counter_o + N'(1);
        // Hold the last issued address once the final element goes out.
        if (counter_o != last_idx) addr_o <= addr_o + step;
      end
    end
  end

endmodule

// File: tb/tb_vector_addr_sequencer.sv
module tb_vector_addr_sequencer;

  localparam int N = 6;

  logic         clk, rst, start, op_type, stall;
  logic [N-1:0] base_addr, stride;
  logic [N-1:0] addr_o, counter_o;
  logic         valid_o, op_type_o, busy_o, done_o;

  int tests  = 0;
  int failed = 0;

  vector_addr_sequencer #(.N(N), .VLEN(20)) dut (
    .clk(clk), .rst(rst), .start(start), .op_type(op_type),
    .base_addr(base_addr), .stride(stride), .stall(stall),
    .addr_o(addr_o), .valid_o(valid_o), .counter_o(counter_o),
    .op_type_o(op_type_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] c, input logic b, input logic d);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".addr"},  32'(addr_o),  32'(a));
    chk({tag, ".cnt"},   32'(counter_o), 32'(c));
    chk({tag, ".busy"},  32'(busy_o),  32'(b));
    chk({tag, ".done"},  32'(done_o),  32'(d));
  endtask

  task automatic issue_start(input logic op, input logic [N-1:0] base, input logic [N-1:0] str);
    start = 1'b1; op_type = op; base_addr = base; stride = str;
    tick();
    start = 1'b0; op_type = 1'b0; base_addr = '0; stride = '0;
  endtask

  initial begin
    logic [N-1:0] ea, ec;
    int           waited;

    rst = 1'b1; start = 1'b0; op_type = 1'b0; base_addr = '0; stride = '0; stall = 1'b0;
    #2;
    chk_all("reset", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("reset.op", 32'(op_type_o), 32'd0);
    #10 rst = 1'b0;
    tick();

    // Vector run, base 10: addresses 10..29, done at T+21, idle at T+22.
    issue_start(1'b1, 6'd10, 6'd0);
    chk("vec.op", 32'(op_type_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk_all($sformatf("vec[%0d]", i), 1'b1, 6'(10 + i), 6'(i), 1'b1, 1'b0);
      tick();
    end
    chk_all("vec.done", 1'b0, 6'd29, 6'd20, 1'b1, 1'b1);
    tick();
    chk_all("vec.idle", 1'b0, 6'd29, 6'd20, 1'b0, 1'b0);
    tick();
    chk_all("vec.hold", 1'b0, 6'd29, 6'd20, 1'b0, 1'b0);

    // Scalar run, base 5: one valid cycle, done at T+2.
    issue_start(1'b0, 6'd5, 6'd0);
    chk_all("sca.t1", 1'b1, 6'd5, 6'd0, 1'b1, 1'b0);
    chk("sca.op", 32'(op_type_o), 32'd0);
    tick();
    chk_all("sca.done", 1'b0, 6'd5, 6'd1, 1'b1, 1'b1);
    tick();
    chk_all("sca.idle", 1'b0, 6'd5, 6'd1, 1'b0, 1'b0);

    // Wrap and stall: base 60, 3 stalled cycles at element 2.
    // Expected: 60,61,62,62,62,62,63,0..15 then done at T+24.
    issue_start(1'b1, 6'd60, 6'd0);
    for (int k = 0; k < 23; k++) begin
      if (k < 3)      begin ea = 6'(60 + k); ec = 6'(k); end
      else if (k < 6) begin ea = 6'd62;      ec = 6'd2;  end
      else            begin ea = 6'(57 + k); ec = 6'(k - 3); end
      chk_all($sformatf("wrap[%0d]", k), 1'b1, ea, ec, 1'b1, 1'b0);
      if (k == 2) stall = 1'b1;
      if (k == 5) stall = 1'b0;
      tick();
    end
    chk_all("wrap.done", 1'b0, 6'd15, 6'd20, 1'b1, 1'b1);
    stall = 1'b1;  // no effect in DONE
    tick();
    stall = 1'b0;
    chk_all("wrap.idle", 1'b0, 6'd15, 6'd20, 1'b0, 1'b0);

    // Step size with stride 4: ignored unless the stride build is selected.
    issue_start(1'b1, 6'd0, 6'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef ADDR_SEQ_STRIDE_EN
      chk($sformatf("str.addr[%0d]", i), 32'(addr_o), 32'(4 * i));
`else
      chk($sformatf("str.addr[%0d]", i), 32'(addr_o), 32'(i));
`endif
      tick();
    end
    // Ignored start in RUN: counter/address keep walking, op_type unchanged.
    start = 1'b1; op_type = 1'b0; base_addr = 6'd33;
    tick();
    start = 1'b0;
`ifdef ADDR_SEQ_STRIDE_EN
    chk_all("ign.run", 1'b1, 6'd20, 6'd5, 1'b1, 1'b0);
`else
    chk_all("ign.run", 1'b1, 6'd5, 6'd5, 1'b1, 1'b0);
`endif
    chk("ign.op", 32'(op_type_o), 32'd1);
    waited = 0;
    while (!done_o && waited < 40) begin
      tick();
      waited++;
    end
    chk("ign.done_seen", 32'(done_o), 32'd1);
    chk("ign.done_lat", 32'(waited), 32'd15);
    // Ignored start in DONE: not queued, state returns to IDLE.
    start = 1'b1; op_type = 1'b0; base_addr = 6'd33;
    tick();
    start = 1'b0;
    chk_all("ign.done", 1'b0, addr_o, 6'd20, 1'b0, 1'b0);
    chk("ign.op2", 32'(op_type_o), 32'd1);
    tick();
    chk("ign.novalid", 32'(valid_o), 32'd0);

    // New start in IDLE clears the counter, then async reset at counter 7.
    issue_start(1'b1, 6'd40, 6'd0);
    chk_all("rst.t1", 1'b1, 6'd40, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk_all("rst.pre", 1'b1, 6'd47, 6'd7, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_all("rst.async", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("rst.op", 32'(op_type_o), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done_o || busy_o || valid_o) begin
        chk("rst.abandon", {29'd0, done_o, busy_o, valid_o}, 32'd0);
        break;
      end
    end
    chk_all("rst.after", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
